// File: rtl/fft_pkg.sv
// Shared widths, mode encodings and FSM state constants for the FFT address path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fft_pkg;

    // Address width: log2(N)
    function automatic int aw_f(input int n);
        return $clog2(n);
    endfunction

    // Twiddle ROM index width: log2(N) - 1
    function automatic int tw_f(input int n);
        return $clog2(n) - 1;
    endfunction

    // Pair index width: log2(N/2)
    function automatic int pw_f(input int n);
        return $clog2(n / 2);
    endfunction

    // Stage index width: log2(log2(N)), never narrower than one bit
    function automatic int sw_f(input int n);
        int c;
        c = $clog2($clog2(n));
        return (c < 1) ? 1 : c;
    endfunction

    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/fft_agu_lane.sv
// Maps (mode, stage, pair) to one butterfly's operand addresses and twiddle index.
// Latency: purely combinational.
// Backpressure: none; the caller registers and holds the inputs.
module fft_agu_lane
    import fft_pkg::*;
#(
    parameter  int N  = 32,
    localparam int AW = aw_f(N),
    localparam int TW = tw_f(N),
    localparam int SW = sw_f(N),
    localparam int PW = pw_f(N)
) (
    input  logic [0:0]    i_mode,
    input  logic [SW-1:0] i_stage,
    input  logic [PW-1:0] i_pair,
    output logic [AW-1:0] o_addr1,
    output logic [AW-1:0] o_addr2,
    output logic [TW-1:0] o_twiddle
);

    localparam logic [AW-1:0] ONES = '1;

    logic [AW-1:0] w_j;
    logic [AW-1:0] w_mask;
    int            w_s;

    assign w_j = {1'b0, i_pair};

    // Lower operand is the pair index with a zero bit inserted at the butterfly span position;
    // w_mask is span-1, so the upper operand is always lower + span.
    always_comb begin
        w_s       = int'(i_stage);
        w_mask    = '0;
        o_addr1   = '0;
        o_twiddle = '0;
        if (i_mode == MODE_DIT) begin
            w_mask    = ~(ONES << w_s);
            o_addr1   = ((w_j >> w_s) << (w_s + 1)) | (w_j & w_mask);
            o_twiddle = TW'(w_j & w_mask) << (AW - 1 - w_s);
        end else begin
            w_mask    = ONES >> (w_s + 1);
            o_addr1   = ((w_j >> (AW - 1 - w_s)) << (AW - w_s)) | (w_j & w_mask);
            o_twiddle = TW'(w_j & w_mask) << w_s;
        end
    end

    assign o_addr2 = o_addr1 + w_mask + AW'(1);

endmodule

// File: rtl/fft_agu_seq.sv
// Self-sequencing radix-2 FFT address generator: walks all stages, LANES butterflies per beat.
// Latency: first beat valid the cycle after start is sampled; one beat per cycle thereafter.
// Backpressure: valid/ready; all outputs hold while out_ready is low; optional bubbles between stages.
module fft_agu_seq
    import fft_pkg::*;
#(
    parameter  int N         = 32,
    parameter  int LANES     = 1,
    parameter  int STAGE_GAP = 0,
    localparam int AW        = aw_f(N),
    localparam int TW        = tw_f(N),
    localparam int SW        = sw_f(N),
    localparam int PW        = pw_f(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [LANES*AW-1:0]   addr1,
    output logic [LANES*AW-1:0]   addr2,
    output logic [LANES*TW-1:0]   twiddle_addr,
    output logic [SW-1:0]         stage,
    output logic                  last_in_stage,
    output logic                  busy,
    output logic                  done
);

    localparam logic [PW-1:0] LAST_BASE   = PW'(N / 2 - LANES);
    localparam logic [PW-1:0] BASE_STEP   = PW'(LANES);
    localparam logic [SW-1:0] FINAL_STAGE = SW'(AW - 1);
    localparam logic [3:0]    GAP_LAST    = 4'(STAGE_GAP - 1);

    logic [1:0]          r_state;
    logic                r_mode;
    logic [SW-1:0]       r_stage;
    logic [PW-1:0]       r_base;
    logic [3:0]          r_gap;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_done;
    logic [LANES*AW-1:0] r_addr1;
    logic [LANES*AW-1:0] r_addr2;
    logic [LANES*TW-1:0] r_tw;

    logic                w_accept;
    logic                w_load;
    logic                w_ld_mode;
    logic [SW-1:0]       w_ld_stage;
    logic [PW-1:0]       w_ld_base;
    logic [LANES*AW-1:0] w_addr1;
    logic [LANES*AW-1:0] w_addr2;
    logic [LANES*TW-1:0] w_tw;

    assign w_accept = r_valid & out_ready;

    // Pick the beat to present next cycle; the lane mappers see it a cycle early so outputs are registered.
    always_comb begin
        w_load     = 1'b0;
        w_ld_mode  = r_mode;
        w_ld_stage = r_stage;
        w_ld_base  = r_base;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_ld_mode  = mode;
                    w_ld_stage = '0;
                    w_ld_base  = '0;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (!r_last) begin
                        w_load    = 1'b1;
                        w_ld_base = r_base + BASE_STEP;
                    end else if (r_stage != FINAL_STAGE && STAGE_GAP == 0) begin
                        w_load     = 1'b1;
                        w_ld_stage = r_stage + SW'(1);
                        w_ld_base  = '0;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_load     = 1'b1;
                    w_ld_stage = r_stage + SW'(1);
                    w_ld_base  = '0;
                end
            end
            default: ;
        endcase
    end

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            fft_agu_lane #(.N(N)) u_lane (
                .i_mode    (w_ld_mode),
                .i_stage   (w_ld_stage),
                .i_pair    (w_ld_base + PW'(l)),
                .o_addr1   (w_addr1[l*AW +: AW]),
                .o_addr2   (w_addr2[l*AW +: AW]),
                .o_twiddle (w_tw[l*TW +: TW])
            );
        end
    endgenerate

    // FSM, counters, gap timer and output registers; reset aborts any transform without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_DIT;
            r_stage <= '0;
            r_base  <= '0;
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_tw    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_state <= ST_RUN;
                r_mode  <= w_ld_mode;
                r_stage <= w_ld_stage;
                r_base  <= w_ld_base;
                r_gap   <= '0;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
                r_last  <= (w_ld_base == LAST_BASE);
                r_addr1 <= w_addr1;
                r_addr2 <= w_addr2;
                r_tw    <= w_tw;
            end else if (r_state == ST_RUN && w_accept) begin
                // Only a stage-final beat reaches here without a follow-on load.
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                if (r_stage == FINAL_STAGE) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ST_GAP;
                    r_gap   <= '0;
                end
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap + 4'd1;
            end
        end
    end

    assign out_valid     = r_valid;
    assign addr1         = r_addr1;
    assign addr2         = r_addr2;
    assign twiddle_addr  = r_tw;
    assign stage         = r_stage;
    assign last_in_stage = r_last;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_fft_agu_seq.sv
// Directed bench for fft_agu_seq: N=32 in three configurations (LANES=1/GAP=0, LANES=1/GAP=2, LANES=4).
// Latency: checks start latency, gap bubble timing and done timing cycle-exactly.
// Backpressure: exercises random out_ready stalls and output stability while stalled.
module tb_fft_agu_seq;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int TW = 4;
    localparam int SW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic rst_n, rst0_n;

    // LANES=1, STAGE_GAP=0
    logic          a_start, a_mode, a_ready, a_valid, a_last, a_busy, a_done;
    logic [AW-1:0] a_addr1, a_addr2;
    logic [TW-1:0] a_tw;
    logic [SW-1:0] a_stage;
    // LANES=1, STAGE_GAP=2
    logic          g_start, g_mode, g_ready, g_valid, g_last, g_busy, g_done;
    logic [AW-1:0] g_addr1, g_addr2;
    logic [TW-1:0] g_tw;
    logic [SW-1:0] g_stage;
    // LANES=4, STAGE_GAP=0
    logic            q_start, q_mode, q_ready, q_valid, q_last, q_busy, q_done;
    logic [4*AW-1:0] q_addr1, q_addr2;
    logic [4*TW-1:0] q_tw;
    logic [SW-1:0]   q_stage;

    fft_agu_seq #(.N(N), .LANES(1), .STAGE_GAP(0)) dut_a (
        .clk(clk), .reset(rst0_n), .start(a_start), .mode(a_mode), .out_ready(a_ready),
        .out_valid(a_valid), .addr1(a_addr1), .addr2(a_addr2), .twiddle_addr(a_tw),
        .stage(a_stage), .last_in_stage(a_last), .busy(a_busy), .done(a_done));

    fft_agu_seq #(.N(N), .LANES(1), .STAGE_GAP(2)) dut_g (
        .clk(clk), .reset(rst_n), .start(g_start), .mode(g_mode), .out_ready(g_ready),
        .out_valid(g_valid), .addr1(g_addr1), .addr2(g_addr2), .twiddle_addr(g_tw),
        .stage(g_stage), .last_in_stage(g_last), .busy(g_busy), .done(g_done));

    fft_agu_seq #(.N(N), .LANES(4), .STAGE_GAP(0)) dut_q (
        .clk(clk), .reset(rst_n), .start(q_start), .mode(q_mode), .out_ready(q_ready),
        .out_valid(q_valid), .addr1(q_addr1), .addr2(q_addr2), .twiddle_addr(q_tw),
        .stage(q_stage), .last_in_stage(q_last), .busy(q_busy), .done(q_done));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Insert a zero bit at position p of j (bitwise walk).
    function automatic int ins0(input int j, input int p);
        int r = 0;
        int b = 0;
        for (int i = 0; i < AW; i++) begin
            if (i != p) begin
                r = r + (((j >> b) & 1) << i);
                b++;
            end
        end
        return r;
    endfunction

    function automatic int m_span(input bit m, input int s);
        return m ? (1 << (AW - 1 - s)) : (1 << s);
    endfunction

    function automatic int m_a1(input bit m, input int s, input int j);
        return m ? ins0(j, AW - 1 - s) : ins0(j, s);
    endfunction

    function automatic int m_tw(input bit m, input int s, input int j);
        return m ? (j % (N >> (s + 1))) * (1 << s) : (j % (1 << s)) * (1 << (AW - 1 - s));
    endfunction

    task automatic hand(input string tag, input int e1, input int e2, input int et);
        chk({tag, "_a1"}, a_addr1, e1);
        chk({tag, "_a2"}, a_addr2, e2);
        chk({tag, "_tw"}, a_tw, et);
    endtask

    // One full transform on dut_a; every accepted beat is compared with the model.
    task automatic run_a(input bit m, input bit stall, input string tag);
        int k, ndone, s, j;
        bit held;
        logic [31:0] cov;
        logic [AW-1:0] pa1, pa2;
        logic [TW-1:0] ptw;
        logic [SW-1:0] pst;
        logic plst;
        k = 0; ndone = 0; held = 0; cov = '0;
        pa1 = '0; pa2 = '0; ptw = '0; pst = '0; plst = 1'b0;
        @(posedge clk); #1;
        a_mode = m; a_start = 1'b1; a_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; a_mode = ~m;
        for (int cyc = 0; cyc < 600 && ndone == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, "_start_lat"}, a_valid, 1);
            if (held) begin
                chk({tag, "_hold_vld"}, a_valid, 1);
                chk({tag, "_hold_a1"}, a_addr1, pa1);
                chk({tag, "_hold_a2"}, a_addr2, pa2);
                chk({tag, "_hold_tw"}, a_tw, ptw);
                chk({tag, "_hold_stg"}, a_stage, pst);
                chk({tag, "_hold_lst"}, a_last, plst);
            end
            if (a_done) ndone++;
            held = a_valid && !a_ready;
            if (a_valid && a_ready) begin
                s = k / 16;
                j = k % 16;
                chk({tag, "_stage"}, a_stage, s);
                chk({tag, "_a1"}, a_addr1, m_a1(m, s, j));
                chk({tag, "_a2"}, a_addr2, m_a1(m, s, j) + m_span(m, s));
                chk({tag, "_tw"}, a_tw, m_tw(m, s, j));
                chk({tag, "_last"}, a_last, (j == 15));
                chk({tag, "_a2_gt_a1"}, a_addr2 > a_addr1, 1);
                if (!m && k == 5)  hand({tag, "_dit_s0p5"}, 10, 11, 0);
                if (!m && k == 37) hand({tag, "_dit_s2p5"}, 9, 13, 4);
                if (!m && k == 69) hand({tag, "_dit_s4p5"}, 5, 21, 5);
                if (m && k == 5)   hand({tag, "_dif_s0p5"}, 5, 21, 5);
                if (m && k == 37)  hand({tag, "_dif_s2p5"}, 9, 13, 4);
                cov = cov | (32'd1 << a_addr1) | (32'd1 << a_addr2);
                if (j == 15) begin
                    chk({tag, "_cover"}, cov, 32'hFFFF_FFFF);
                    cov = '0;
                end
                k++;
            end
            pa1 = a_addr1; pa2 = a_addr2; ptw = a_tw; pst = a_stage; plst = a_last;
            @(posedge clk); #1;
            a_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            a_start = (cyc == 30);
        end
        a_start = 1'b0;
        chk({tag, "_beats"}, k, 80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_done) ndone++;
        end
        chk({tag, "_done_once"}, ndone, 1);
        chk({tag, "_idle_busy"}, a_busy, 0);
        chk({tag, "_idle_vld"}, a_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int ndone, lastv, firstd, nv, nb;
        bit gv[0:99];
        bit gl[0:99];
        bit gd[0:99];

        rst_n = 1'b0; rst0_n = 1'b0;
        a_start = 1'b0; a_mode = 1'b0; a_ready = 1'b1;
        g_start = 1'b0; g_mode = 1'b0; g_ready = 1'b1;
        q_start = 1'b0; q_mode = 1'b0; q_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_vld", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_a1", a_addr1, 0);
        chk("rst_a2", a_addr2, 0);
        chk("rst_tw", a_tw, 0);
        chk("rst_stage", a_stage, 0);
        chk("rst_last", a_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; rst0_n = 1'b1;
        @(negedge clk);
        chk("idle_vld", a_valid, 0);

        run_a(1'b0, 1'b0, "dit");
        run_a(1'b1, 1'b0, "dif");
        run_a(1'b0, 1'b1, "dit_stall");
        run_a(1'b1, 1'b1, "dif_stall");

        // Abort in the middle of stage 2, then restart cleanly.
        @(posedge clk); #1;
        a_mode = 1'b0; a_start = 1'b1; a_ready = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (a_valid && a_stage == 3'd2) seen = 1;
        end
        chk("abort_reach_s2", seen, 1);
        repeat (5) @(negedge clk);
        #2 rst0_n = 1'b0;
        #1;
        chk("abort_vld", a_valid, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_a1", a_addr1, 0);
        chk("abort_a2", a_addr2, 0);
        chk("abort_tw", a_tw, 0);
        chk("abort_stage", a_stage, 0);
        chk("abort_last", a_last, 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_done) ndone++;
        end
        @(posedge clk); #1;
        rst0_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_done || a_valid) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_a(1'b0, 1'b0, "restart");

        // Stage gap timing: edge 0 samples start.
        @(posedge clk); #1;
        g_start = 1'b1;
        @(posedge clk); #1;
        g_start = 1'b0;
        for (int c = 1; c <= 95; c++) begin
            @(negedge clk);
            gv[c] = g_valid; gl[c] = g_last; gd[c] = g_done;
            @(posedge clk); #1;
            g_start = (c == 88);
        end
        g_start = 1'b0;
        lastv = 0; firstd = 0; ndone = 0; nv = 0;
        for (int c = 1; c <= 89; c++) begin
            if (gv[c]) begin lastv = c; nv++; end
            if (gd[c]) begin ndone++; if (firstd == 0) firstd = c; end
        end
        chk("gap_first_valid", gv[1], 1);
        chk("gap_beats", nv, 80);
        chk("gap_last_beat_cycle", lastv, 88);
        chk("gap_done_cycle", firstd, 89);
        chk("gap_done_once", ndone, 1);
        for (int s = 0; s < 4; s++) begin
            chk("gap_stage_last", gl[16 + 18 * s], 1);
            chk("gap_bubble1", gv[17 + 18 * s], 0);
            chk("gap_bubble2", gv[18 + 18 * s], 0);
            chk("gap_resume", gv[19 + 18 * s], 1);
        end
        chk("gap_start_at_done", gv[90], 1);

        // Four lanes per beat.
        @(posedge clk); #1;
        q_start = 1'b1;
        @(posedge clk); #1;
        q_start = 1'b0;
        nb = 0; ndone = 0;
        for (int c = 0; c < 100 && ndone == 0; c++) begin
            @(negedge clk);
            if (q_done) ndone++;
            if (q_valid) begin
                if (nb == 1) begin
                    for (int l = 0; l < 4; l++) begin
                        chk("l4_b1_a1", q_addr1[l*AW +: AW], 8 + 2 * l);
                        chk("l4_b1_a2", q_addr2[l*AW +: AW], 9 + 2 * l);
                    end
                    chk("l4_b1_last", q_last, 0);
                end
                if (nb == 3) chk("l4_b3_last", q_last, 1);
                if (nb == 4) chk("l4_b4_stage", q_stage, 1);
                if (nb == 19) begin
                    chk("l4_b19_a2_l0", q_addr2[0 +: AW], 28);
                    chk("l4_b19_tw_l3", q_tw[3*TW +: TW], 15);
                end
                nb++;
            end
        end
        chk("l4_beats", nb, 20);
        chk("l4_done", ndone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
